// File: rtl/factorial_engine.sv
// -----------------------------------------------------------------------------
// factorial_engine
//
// Iterative factorial (n!) and double-factorial (n!!) generator. It performs one
// multiply per clock and offers a load/done/dack handshake that also allows
// back-to-back requests. If the true result does not fit in PROD_W bits, the
// product saturates to all ones and ovf is raised.
//
// Parameters
//   OP_W    operand width (2..16)
//   PROD_W  product width (>= OP_W)
//
// Ports
//   clk      in   rising-edge clock
//   rst      in   asynchronous, active-low reset
//   load     in   request strobe; samples operand and mode when accepted
//   mode     in   0 = n!, 1 = n!!
//   operand  in   n, unsigned, OP_W bits
//   dack     in   result acknowledge from the consumer
//   product  out  result, PROD_W bits, meaningful while done=1
//   done     out  result ready, held until acknowledged
//   ovf      out  result exceeded PROD_W bits (saturated), valid with done
//   busy     out  high while a request is running or waiting for dack
// -----------------------------------------------------------------------------
module factorial_engine #(
  parameter int OP_W   = 4,
  parameter int PROD_W = 41
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              mode,
  input  logic [OP_W-1:0]   operand,
  input  logic              dack,
  output logic [PROD_W-1:0] product,
  output logic              done,
  output logic              ovf,
  output logic              busy
);

  localparam int FULL_W = PROD_W + OP_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [PROD_W-1:0]   acc_q,   acc_d;
  logic [OP_W-1:0]     cnt_q,   cnt_d;
  logic                step_q,  step_d;
  logic                ovf_q,   ovf_d;
  logic                done_q,  done_d;
  logic                busy_q,  busy_d;
  logic                accept;

  // Multiply the accumulator by the current factor at full width. Any set bit
  // above PROD_W means overflow. Once overflow has occurred, the accumulator
  // stays pinned at all ones for the rest of the request.
  // Returns {ovf, acc}.
  function automatic logic [PROD_W:0] mul_sat(
    input logic [PROD_W-1:0] acc_in,
    input logic [OP_W-1:0]   fac_in,
    input logic              ovf_in
  );
    logic [FULL_W-1:0] full;
    full = FULL_W'(acc_in) * FULL_W'(fac_in);
    if (ovf_in || (full[FULL_W-1:PROD_W] != '0)) begin
      mul_sat = {1'b1, {PROD_W{1'b1}}};
    end else begin
      mul_sat = {1'b0, full[PROD_W-1:0]};
    end
  endfunction

  // Next factor. In double-factorial mode the factor steps by two, and cnt=1
  // saturates to 0 instead of wrapping.
  function automatic logic [OP_W-1:0] next_cnt(
    input logic [OP_W-1:0] cnt_in,
    input logic            step_in
  );
    if (!step_in) begin
      next_cnt = cnt_in - OP_W'(1);
    end else if (cnt_in < OP_W'(2)) begin
      next_cnt = '0;
    end else begin
      next_cnt = cnt_in - OP_W'(2);
    end
  endfunction

  // A request is taken from IDLE, or from DONE when dack is in the same cycle.
  // The second case lets a new request start without a gap.
  assign accept = load && ((state_q == S_IDLE) ||
                           ((state_q == S_DONE) && dack));

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    step_d  = step_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      S_IDLE: begin
        // wait for load (handled by accept below)
      end
      S_RUN: begin
        if (cnt_q != '0) begin
          // A factor of 1 is still multiplied so latency depends only on n.
          {ovf_d, acc_d} = mul_sat(acc_q, cnt_q, ovf_q);
          cnt_d          = next_cnt(cnt_q, step_q);
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (dack) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (accept) begin
      acc_d   = PROD_W'(1);
      cnt_d   = operand;
      step_d  = mode;
      ovf_d   = 1'b0;
      state_d = S_RUN;
    end

    // done and busy are registered copies of the next state, so each one
    // changes on the same edge as the state it reflects.
    done_d = (state_d == S_DONE);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      step_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign product = acc_q;
  assign ovf     = ovf_q;
  assign done    = done_q;
  assign busy    = busy_q;

endmodule

// File: doc/factorial_engine.md
# factorial_engine

Parametrised iterative factorial / double-factorial generator with a load/done/dack handshake, overflow detection and back-to-back issue. It replaces the fixed 4-bit-operand / 41-bit-product factorial block. Operand and product widths are set by parameters, and the operation is selected per request. It sits behind the same testbench-facing handshake interface, one multiply per clock.

## Interface
- OP_W, default 4: operand width. Legal range 2..16.
- PROD_W, default 41: product width. Must be at least OP_W.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- load  input  1  request strobe; samples operand and mode on the edge where it is accepted.
- mode  input  1  0 = n!, 1 = n!! (double factorial).
- operand  input  OP_W  n, unsigned.
- dack  input  1  result acknowledge from the consumer.
- product  output  PROD_W  result; valid only while done=1.
- done  output  1  result ready; held until acknowledged.
- ovf  output  1  true result exceeded PROD_W bits; valid with done.
- busy  output  1  high in RUN and DONE; low in IDLE.

## Operation
- State machine has three states: IDLE, RUN, DONE. Registers: acc (PROD_W), cnt (OP_W), step (1 bit), state, ovf.
- Reset (rst=0, asynchronous): state=IDLE, acc=0, cnt=0, done=0, busy=0, ovf=0. product outputs acc, so product reads 0.
- Accept rule: load is accepted when state=IDLE, or when state=DONE and dack=1 in the same cycle (back-to-back issue).
  - On accept: acc=1, cnt=operand, step=mode, ovf=0, state goes to RUN.
  - load in RUN, or in DONE without dack, is ignored. No queueing.
- RUN, each edge:
  - If cnt!=0:
    - Compute full = acc*cnt at PROD_W+OP_W bits.
    - If ovf=1 or full[PROD_W+OP_W-1:PROD_W]!=0: acc = all ones, ovf=1. Otherwise acc = full[PROD_W-1:0].
    - cnt = cnt-1 when step=0. When step=1, cnt = cnt-2, saturating at 0 (cnt=1 goes to 0).
  - If cnt==0: state goes to DONE, acc unchanged.
- DONE: done=1. product and ovf are stable.
  - dack=1 without load: go to IDLE.
  - dack=1 with load: restart as above.
  - dack=0: hold indefinitely.
- dack in IDLE or RUN is ignored.
- Saturation is sticky: once ovf=1, product is all ones for the rest of that request.
- Multiplying by the factor 1 is harmless and is not skipped, so latency stays uniform.

## Timing
- Define K = n for mode 0 and K = ceil(n/2) for mode 1.
- Count the accepting edge as edge 0. done rises after edge K+1 and is first sampled high on that clock's following edge.
  - Mode 0: n=0 gives done after edge 1; n=15 gives done after edge 16.
  - Mode 1: n=0 gives done after edge 1; n=1 after edge 2; n=8 after edge 5.
- busy rises after edge 0 and falls after the edge where dack is taken. For a back-to-back restart, busy stays high continuously.
- For a back-to-back restart, done falls after the dack edge and the new latency counts from that edge.
- done never asserts in a cycle where state!=DONE. Between the accepting edge and done, done stays 0 for exactly K+1 edges.
- Minimum request-to-request period is K+2 edges, with dack tied high.
- Asynchronous reset in RUN or DONE: all outputs go to reset values immediately. A load arriving with rst released is accepted on the next edge as from IDLE.

## Test plan
- Defaults, mode 0, operands 0, 1, 5, 15 one at a time with dack one cycle after done:
  - product = 1, 1, 120, 1307674368000.
  - done after edges 1, 2, 6, 16 respectively.
  - ovf=0 throughout.
- Mode 1, operands 7, 8, 15:
  - product = 105, 384, 2027025.
  - done after edges 5, 5, 9.
  - ovf=0.
- PROD_W=16:
  - 8! gives 40320, ovf=0.
  - 9! gives 16'hFFFF, ovf=1.
  - Then 3! gives 6 with ovf cleared.
- dack held low 20 cycles after done, with load pulsed during RUN and DONE:
  - done, product and ovf stay stable.
  - Both loads are ignored.
  - busy stays high.
- Back-to-back: load=1 together with dack=1 in DONE (5! then 4!):
  - busy never drops.
  - done low for exactly 5 edges.
  - Second product = 24.
- rst pulsed low mid-RUN (10!, after edge 4):
  - product=0, done=0, busy=0, ovf=0 immediately.
  - Next load of 3 yields 6 after edge 4.
